// File: rtl/key_debounce.sv
// key_debounce: cleans one raw push-button pin into a debounced level with
// one-cycle press / release / long-press pulses and a wrapping press count.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned LONG_CYCLES     = 24000000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_state,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [7:0] press_cnt
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LGW = $clog2(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_FIRST = DBW'(1);
    localparam logic [LGW-1:0] LG_LAST  = LGW'(LONG_CYCLES - 1);
    localparam logic PIN_IDLE = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        LONG_HELD,
        DB_RELEASE
    } state_t;

    state_t         state, state_nx;
    logic           sync_a, sync_b, key_sync;
    logic [DBW-1:0] db_cnt, db_cnt_nx;
    logic [LGW-1:0] long_cnt, long_cnt_nx;
    logic           from_long, from_long_nx;
    logic           key_state_nx, press_nx, release_nx, long_nx;
    logic [7:0]     press_cnt_nx;

    // Two-flop synchronizer, reset to the released pin level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= PIN_IDLE;
            sync_b <= PIN_IDLE;
        end else begin
            sync_a <= key_in;
            sync_b <= sync_a;
        end
    end

    // Polarity applied after synchronization: 1 = pressed
    assign key_sync = sync_b ^ PIN_IDLE;

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            long_cnt    <= '0;
            from_long   <= 1'b0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            press_cnt   <= '0;
        end else begin
            state       <= state_nx;
            db_cnt      <= db_cnt_nx;
            long_cnt    <= long_cnt_nx;
            from_long   <= from_long_nx;
            key_state   <= key_state_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            key_long    <= long_nx;
            press_cnt   <= press_cnt_nx;
        end
    end

    // Next-state and next-output decode; release path has priority over long expiry
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        long_cnt_nx  = long_cnt;
        from_long_nx = from_long;
        key_state_nx = key_state;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;
        press_cnt_nx = press_cnt;
        unique case (state)
            IDLE: begin
                if (key_sync) begin
                    state_nx  = DB_PRESS;
                    db_cnt_nx = DB_FIRST;
                end
            end
            DB_PRESS: begin
                if (!key_sync) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nx     = PRESSED;
                    key_state_nx = 1'b1;
                    press_nx     = 1'b1;
                    press_cnt_nx = press_cnt + 8'd1;
                    long_cnt_nx  = '0;
                end else if (db_cnt != '1) begin
                    db_cnt_nx = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!key_sync) begin
                    state_nx     = DB_RELEASE;
                    db_cnt_nx    = DB_FIRST;
                    from_long_nx = 1'b0;
                end else if (long_cnt == LG_LAST) begin
                    state_nx = LONG_HELD;
                    long_nx  = 1'b1;
                end else if (long_cnt != '1) begin
                    long_cnt_nx = long_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!key_sync) begin
                    state_nx     = DB_RELEASE;
                    db_cnt_nx    = DB_FIRST;
                    from_long_nx = 1'b1;
                end
            end
            DB_RELEASE: begin
                // Long counter is held here and resumes on return to PRESSED
                if (key_sync) begin
                    state_nx = from_long ? LONG_HELD : PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nx     = IDLE;
                    key_state_nx = 1'b0;
                    release_nx   = 1'b1;
                end else if (db_cnt != '1) begin
                    db_cnt_nx = db_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scenario tasks plus randomized runs, each cycle compared
// against a window-based reference model of the button behaviour.
module tb_key_debounce;

    localparam int DB = 8;
    localparam int LC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b1;
    logic       key_state, key_press, key_release, key_long;
    logic [7:0] press_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [1:0] m_pipe;
    bit         win[$];
    bit         m_level, m_prev_ks, m_long_done;
    bit         e_press, e_release, e_long;
    int         m_long;
    logic [7:0] m_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LC),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pipe = 2'b11;
        win.delete();
        m_level = 0; m_prev_ks = 0; m_long_done = 0;
        e_press = 0; e_release = 0; e_long = 0;
        m_long = 0;
        m_cnt = '0;
    endtask

    // One clock edge of the model: the level flips once the last DB synchronized
    // samples all disagree with it; long fires on the LC-th held-and-stable edge.
    task automatic model_step();
        bit ks, all_diff;
        ks = !m_pipe[1];
        m_pipe = {m_pipe[0], key_in};
        e_press = 0; e_release = 0; e_long = 0;
        win.push_back(ks);
        if (win.size() > DB) void'(win.pop_front());
        all_diff = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_level) all_diff = 0;
        if (all_diff) begin
            m_level = !m_level;
            if (m_level) begin
                e_press = 1; m_cnt = m_cnt + 8'd1; m_long = 0; m_long_done = 0;
            end else begin
                e_release = 1;
            end
        end else if (m_level && ks && m_prev_ks && !m_long_done) begin
            m_long++;
            if (m_long == LC) begin
                e_long = 1; m_long_done = 1;
            end
        end
        m_prev_ks = ks;
    endtask

    task automatic do_reset();
        key_in = 1'b1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        if ({key_state, key_press, key_release, key_long, press_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", {key_state, key_press, key_release, key_long, press_cnt}, 12'd0);
        end
        checks++;
        do_reset();
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== 12'd0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, 12'd0);
            end
            checks++;
        end
    endtask

    task automatic test_press_release();
        int pcyc = -1, rcyc = -1, nlong = 0;
        do_reset();
        key_in = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                errors++;
                $display("FAIL press_release cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
            end
            checks++;
            if (key_press) pcyc = c;
            if (key_release) rcyc = c;
            if (key_long) nlong++;
            if (c == 30) key_in = 1'b1;
        end
        if (pcyc != 10) begin errors++; $display("FAIL press_cycle got=%0d exp=10", pcyc); end
        checks++;
        if (rcyc != 40) begin errors++; $display("FAIL release_cycle got=%0d exp=40", rcyc); end
        checks++;
        if (press_cnt !== 8'd1) begin errors++; $display("FAIL press_cnt_one got=%0d exp=1", press_cnt); end
        checks++;
        if (nlong != 0) begin errors++; $display("FAIL no_long got=%0d exp=0", nlong); end
        checks++;
    endtask

    task automatic test_bounce();
        int npress = 0, pcyc = -1;
        do_reset();
        key_in = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                errors++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
            end
            checks++;
            if (key_press) begin npress++; pcyc = c; end
            key_in = (c < 30) ? (((c / 3) % 2) == 1) : 1'b0;
        end
        if (npress != 1 || pcyc != 40) begin
            errors++;
            $display("FAIL bounce_single_press got=%0d@%0d exp=1@40", npress, pcyc);
        end
        checks++;
        if (press_cnt !== 8'd1) begin errors++; $display("FAIL bounce_cnt got=%0d exp=1", press_cnt); end
        checks++;
    endtask

    task automatic test_long();
        int pcyc = -1, lcyc = -1, nlong = 0, nrel_held = 0;
        do_reset();
        key_in = 1'b0;
        for (int c = 1; c <= 115; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                errors++;
                $display("FAIL long_press cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
            end
            checks++;
            if (key_press) pcyc = c;
            if (key_long) begin nlong++; lcyc = c; end
            if (key_release && c <= 100) nrel_held++;
            if (c == 60) key_in = 1'b1;
            if (c == 65) key_in = 1'b0;
            if (c == 100) key_in = 1'b1;
        end
        if (pcyc != 10) begin errors++; $display("FAIL long_press_cycle got=%0d exp=10", pcyc); end
        checks++;
        if (nlong != 1 || lcyc != 50) begin errors++; $display("FAIL long_single got=%0d@%0d exp=1@50", nlong, lcyc); end
        checks++;
        if (nrel_held != 0) begin errors++; $display("FAIL glitch_no_release got=%0d exp=0", nrel_held); end
        checks++;
    endtask

    task automatic test_wrap();
        int npress = 0, nrel = 0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            key_in = 1'b0;
            for (int i = 1; i <= 24; i++) begin
                @(negedge clk);
                model_step();
                if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                    errors++;
                    $display("FAIL wrap p=%0d i=%0d got=%b exp=%b", p, i, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
                end
                checks++;
                if (key_press) npress++;
                if (key_release) nrel++;
                if (i == 12) key_in = 1'b1;
            end
        end
        if (npress != 256 || nrel != 256) begin
            errors++;
            $display("FAIL wrap_pulses got=%0d/%0d exp=256/256", npress, nrel);
        end
        checks++;
        if (press_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got=%0d exp=0", press_cnt); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int pcyc = -1;
        do_reset();
        key_in = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
            end
            checks++;
        end
        rst = 1'b1;
        #1;
        model_reset();
        if ({key_state, key_press, key_release, key_long, press_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset_clear got=%b exp=%b", {key_state, key_press, key_release, key_long, press_cnt}, 12'd0);
        end
        checks++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            model_step();
            if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", c, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
            end
            checks++;
            if (key_press) pcyc = c;
        end
        if (pcyc != 10 || press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL fresh_press got=%0d@%0d exp=1@10", press_cnt, pcyc);
        end
        checks++;
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            key_in = $urandom_range(0, 1);
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                model_step();
                if ({key_state, key_press, key_release, key_long, press_cnt} !== {m_level, e_press, e_release, e_long, m_cnt}) begin
                    errors++;
                    $display("FAIL random s=%0d i=%0d got=%b exp=%b", s, i, {key_state, key_press, key_release, key_long, press_cnt}, {m_level, e_press, e_release, e_long, m_cnt});
                end
                checks++;
                if (key_press && key_release) begin
                    errors++;
                    $display("FAIL press_release_overlap s=%0d i=%0d got=11 exp=not both", s, i);
                end
                checks++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_bounce();
        test_long();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
